// File: rtl/note_pkg.sv
// note_pkg: shared defaults and helpers for the note lane engine.
//   - default geometry / timing parameters for note_lane_engine and note_lane
//   - HIT_BASE: points awarded for a hit before the combo bonus
//   - lane_idx_t: lane index type for the default lane count
//   - saturating helpers for the score and combo counters
package note_pkg;

  localparam int NUM_LANES_DEF  = 5;
  localparam int DEPTH_DEF      = 8;
  localparam int SPEED_DEF      = 4;
  localparam int HIT_Y_DEF      = 440;
  localparam int HIT_WIN_DEF    = 12;
  localparam int NOTE_H_DEF     = 16;
  localparam int NOTE_W_DEF     = 48;
  localparam int LANE_X0_DEF    = 120;
  localparam int LANE_PITCH_DEF = 80;

  localparam logic [15:0] HIT_BASE = 16'd10;

  localparam int LANE_IDX_W = $clog2(NUM_LANES_DEF);
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // 16-bit add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? 8'hFF : a + 8'd1;
  endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane: one lane of falling notes.
//   Clk, Reset_n      : clock, async active-low reset
//   tick              : one-cycle frame advance strobe
//   spawn             : write a new note (y=0) at the tail; ignored when full
//   pop_hit           : judged hit on this lane; pops the head if in window
//   DrawX, DrawY      : current pixel coordinate
//   full              : lane holds DEPTH notes
//   in_win            : head note is live and within the strike window
//   miss_det          : head note has passed below the window (pops this cycle)
//   is_note           : current pixel lies inside a live note of this lane
module note_lane
  import note_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int SPEED   = SPEED_DEF,
  parameter int HIT_Y   = HIT_Y_DEF,
  parameter int HIT_WIN = HIT_WIN_DEF,
  parameter int NOTE_H  = NOTE_H_DEF,
  parameter int NOTE_W  = NOTE_W_DEF,
  parameter int LANE_X  = LANE_X0_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       tick,
  input  logic       spawn,
  input  logic       pop_hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       full,
  output logic       in_win,
  output logic       miss_det,
  output logic       is_note
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [11:0] WIN_HI = 12'(HIT_Y + HIT_WIN);
  localparam logic [11:0] X_LO   = 12'(LANE_X);
  localparam logic [11:0] X_HI   = 12'(LANE_X + NOTE_W);

  logic [9:0]       y_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [DEPTH-1:0] live_s;
  logic [11:0]      head_y_s;
  logic             push_s;
  logic             pop_s;
  logic             x_ok_s;

  // a slot is live when its distance from the head is below the count
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      live_s[j] = ({1'b0, PW'(PW'(j) - head_r)} < count_r);
    end
  end

  // head judgement flags and FIFO push/pop qualification
  always_comb begin
    head_y_s = {2'b00, y_r[head_r]};
    full     = (count_r == CW'(DEPTH));
    miss_det = (count_r != {CW{1'b0}}) && (head_y_s > WIN_HI);
    // lower bound written as y+WIN >= HIT_Y so it cannot underflow
    in_win   = (count_r != {CW{1'b0}}) &&
               ((head_y_s + 12'(HIT_WIN)) >= 12'(HIT_Y)) && (head_y_s <= WIN_HI);
    push_s   = spawn && !full;
    pop_s    = (pop_hit && in_win) || miss_det;
  end

  // FIFO pointers, count and per-slot y positions
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int j = 0; j < DEPTH; j++) begin
        y_r[j] <= 10'd0;
      end
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
      // the tail slot is never live when pushing, so a fresh note skips this tick
      for (int j = 0; j < DEPTH; j++) begin
        if (push_s && (PW'(j) == tail_r)) begin
          y_r[j] <= 10'd0;
        end else if (tick && live_s[j]) begin
          y_r[j] <= y_r[j] + 10'(SPEED);
        end
      end
    end
  end

  // pixel-in-note test over all live slots
  always_comb begin
    x_ok_s  = ({2'b00, DrawX} >= X_LO) && ({2'b00, DrawX} < X_HI);
    is_note = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      is_note = is_note | (x_ok_s && live_s[j] &&
                           ({2'b00, DrawY} >= {2'b00, y_r[j]}) &&
                           ({2'b00, DrawY} < ({2'b00, y_r[j]} + 12'(NOTE_H))));
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: rhythm-game note lanes with spawn, fall, hit/miss judgement
// and scoring.
//   Clk, Reset_n               : 50 MHz clock, async active-low reset
//   frame_clk                  : VGA vsync; each rising edge advances notes
//   spawn_valid/lane/ready     : note-spawn handshake (ready = lane not full)
//   lane_press                 : level fret keys, one bit per lane
//   DrawX, DrawY               : current pixel coordinate
//   is_note                    : pixel lies in a live note, per lane
//   hit_pulse, miss_pulse      : one-cycle judgement strobes, per lane
//   score, combo               : running totals
module note_lane_engine
  import note_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int SPEED      = SPEED_DEF,
  parameter int HIT_Y      = HIT_Y_DEF,
  parameter int HIT_WIN    = HIT_WIN_DEF,
  parameter int NOTE_H     = NOTE_H_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int LANE_X0    = LANE_X0_DEF,
  parameter int LANE_PITCH = LANE_PITCH_DEF
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic                         spawn_valid,
  input  logic [$clog2(NUM_LANES)-1:0] spawn_lane,
  output logic                         spawn_ready,
  input  logic [NUM_LANES-1:0]         lane_press,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic [NUM_LANES-1:0]         is_note,
  output logic [NUM_LANES-1:0]         hit_pulse,
  output logic [NUM_LANES-1:0]         miss_pulse,
  output logic [15:0]                  score,
  output logic [7:0]                   combo
);

  logic [1:0]           frame_sync_r;
  logic                 frame_prev_r;
  logic [NUM_LANES-1:0] press_d_r;
  logic [NUM_LANES-1:0] press_prev_r;
  logic [NUM_LANES-1:0] pending_r;
  logic [NUM_LANES-1:0] hit_pulse_r;
  logic [NUM_LANES-1:0] miss_pulse_r;
  logic [15:0]          score_r;
  logic [7:0]           combo_r;

  logic                 tick_s;
  logic [NUM_LANES-1:0] rise_s;
  logic [NUM_LANES-1:0] grant_s;
  logic [NUM_LANES-1:0] hit_s;
  logic                 ghost_s;
  logic                 found_s;
  logic [NUM_LANES-1:0] spawn_en_s;
  logic [NUM_LANES-1:0] full_s;
  logic [NUM_LANES-1:0] in_win_s;
  logic [NUM_LANES-1:0] miss_s;
  logic [15:0]          score_nxt_s;
  logic [7:0]           combo_nxt_s;
  logic                 sel_s;

  // frame tick, press edges, lowest-index grant and spawn steering
  always_comb begin
    tick_s  = frame_sync_r[1] & ~frame_prev_r;
    rise_s  = press_d_r & ~press_prev_r;
    found_s = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      grant_s[i] = pending_r[i] & ~found_s;
      found_s    = found_s | pending_r[i];
    end
    hit_s   = grant_s & in_win_s;
    ghost_s = (grant_s != {NUM_LANES{1'b0}}) && (hit_s == {NUM_LANES{1'b0}});
    // an out-of-range spawn_lane selects nothing and reads as not ready
    spawn_ready = 1'b0;
    sel_s       = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sel_s         = (int'(spawn_lane) == i);
      spawn_ready   = spawn_ready | (sel_s & ~full_s[i]);
      spawn_en_s[i] = spawn_valid & sel_s & ~full_s[i];
    end
  end

  // score and combo update; any miss or ghost in the cycle breaks the combo
  always_comb begin
    score_nxt_s = score_r;
    combo_nxt_s = combo_r;
    if (hit_s != {NUM_LANES{1'b0}}) begin
      score_nxt_s = sat_add16(score_r, HIT_BASE + {8'd0, combo_r});
      combo_nxt_s = sat_inc8(combo_r);
    end else begin
      combo_nxt_s = combo_r;
    end
    if (ghost_s || (miss_s != {NUM_LANES{1'b0}})) begin
      combo_nxt_s = 8'd0;
    end else begin
      combo_nxt_s = combo_nxt_s;
    end
  end

  // synchronisers, pending presses, strobes and totals
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_r <= 2'b00;
      frame_prev_r <= 1'b0;
      press_d_r    <= {NUM_LANES{1'b0}};
      press_prev_r <= {NUM_LANES{1'b0}};
      pending_r    <= {NUM_LANES{1'b0}};
      hit_pulse_r  <= {NUM_LANES{1'b0}};
      miss_pulse_r <= {NUM_LANES{1'b0}};
      score_r      <= 16'd0;
      combo_r      <= 8'd0;
    end else begin
      frame_sync_r <= {frame_sync_r[0], frame_clk};
      frame_prev_r <= frame_sync_r[1];
      press_d_r    <= lane_press;
      press_prev_r <= press_d_r;
      pending_r    <= (pending_r & ~grant_s) | rise_s;
      hit_pulse_r  <= hit_s;
      miss_pulse_r <= miss_s;
      score_r      <= score_nxt_s;
      combo_r      <= combo_nxt_s;
    end
  end

  assign hit_pulse  = hit_pulse_r;
  assign miss_pulse = miss_pulse_r;
  assign score      = score_r;
  assign combo      = combo_r;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    note_lane #(
      .DEPTH   (DEPTH),
      .SPEED   (SPEED),
      .HIT_Y   (HIT_Y),
      .HIT_WIN (HIT_WIN),
      .NOTE_H  (NOTE_H),
      .NOTE_W  (NOTE_W),
      .LANE_X  (LANE_X0 + gi * LANE_PITCH)
    ) u_lane (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .tick     (tick_s),
      .spawn    (spawn_en_s[gi]),
      .pop_hit  (hit_s[gi]),
      .DrawX    (DrawX),
      .DrawY    (DrawY),
      .full     (full_s[gi]),
      .in_win   (in_win_s[gi]),
      .miss_det (miss_s[gi]),
      .is_note  (is_note[gi])
    );
  end

endmodule

// File: tb/tb_note_lane_engine.sv
module tb_note_lane_engine;
  import note_pkg::*;

  localparam int NL = 5;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_clk = 1'b0;
  logic          spawn_valid = 1'b0;
  lane_idx_t     spawn_lane = '0;
  logic          spawn_ready;
  logic [NL-1:0] lane_press = '0;
  logic [9:0]    DrawX = 10'd0;
  logic [9:0]    DrawY = 10'd0;
  logic [NL-1:0] is_note;
  logic [NL-1:0] hit_pulse;
  logic [NL-1:0] miss_pulse;
  logic [15:0]   score;
  logic [7:0]    combo;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: list of note y positions per lane, oldest first
  int q[NL][$];
  int m_score = 0;
  int m_combo = 0;
  int exp_hits[NL] = '{default: 0};
  int exp_miss[NL] = '{default: 0};
  int obs_hits[NL] = '{default: 0};
  int obs_miss[NL] = '{default: 0};

  always #10 Clk = ~Clk;

  note_lane_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .lane_press(lane_press), .DrawX(DrawX), .DrawY(DrawY),
    .is_note(is_note), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .combo(combo)
  );

  // tally judgement strobes seen on the outputs
  always @(negedge Clk) begin
    for (int i = 0; i < NL; i++) begin
      obs_hits[i] += int'(hit_pulse[i]);
      obs_miss[i] += int'(miss_pulse[i]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] model_pix(input int x, input int y);
    logic [NL-1:0] v = '0;
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < q[l].size(); k++) begin
        if (x >= 120 + 80*l && x < 120 + 80*l + 48 && y >= q[l][k] && y < q[l][k] + 16)
          v[l] = 1'b1;
      end
    end
    return v;
  endfunction

  // lanes judged lowest first; hit when |y-440|<=12, otherwise ghost
  task automatic model_judge(input logic [NL-1:0] mask);
    for (int l = 0; l < NL; l++) begin
      if (mask[l]) begin
        if (q[l].size() > 0 && q[l][0] >= 428 && q[l][0] <= 452) begin
          void'(q[l].pop_front());
          m_score = (m_score + 10 + m_combo > 65535) ? 65535 : m_score + 10 + m_combo;
          m_combo = (m_combo == 255) ? 255 : m_combo + 1;
          exp_hits[l]++;
        end else begin
          m_combo = 0;
        end
      end
    end
  endtask

  task automatic model_tick();
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < q[l].size(); k++) q[l][k] += 4;
      while (q[l].size() > 0 && q[l][0] > 452) begin
        void'(q[l].pop_front());
        exp_miss[l]++;
        m_combo = 0;
      end
    end
  endtask

  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    model_tick();
  endtask

  task automatic do_spawn(input int l);
    @(negedge Clk);
    spawn_valid = 1'b1;
    spawn_lane  = lane_idx_t'(l);
    #1 chk("spawn_ready", 32'(spawn_ready), 32'(q[l].size() < 8));
    @(negedge Clk) spawn_valid = 1'b0;
    if (q[l].size() < 8) q[l].push_back(0);
  endtask

  task automatic do_press(input logic [NL-1:0] mask, input int hold);
    @(negedge Clk) lane_press = mask;
    repeat (hold) @(negedge Clk);
    lane_press = '0;
    repeat (NL + 3) @(negedge Clk);
    model_judge(mask);
  endtask

  task automatic check_pix(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 chk("is_note", 32'(is_note), 32'(model_pix(x, y)));
  endtask

  task automatic pix_bit(input int x, input int y, input int l, input logic e);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 chk("is_note_bit", 32'(is_note[l]), 32'(e));
  endtask

  task automatic check_totals();
    @(negedge Clk);
    #1;
    chk("score", 32'(score), 32'(m_score));
    chk("combo", 32'(combo), 32'(m_combo));
    for (int l = 0; l < NL; l++) begin
      chk("hit_count", 32'(obs_hits[l]), 32'(exp_hits[l]));
      chk("miss_count", 32'(obs_miss[l]), 32'(exp_miss[l]));
    end
  endtask

  initial begin
    int r;
    int l;
    int x;
    int y;
    logic [NL-1:0] mask;

    // reset state
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_combo", 32'(combo), 32'd0);
    chk("rst_hit", 32'(hit_pulse), 32'd0);
    chk("rst_miss", 32'(miss_pulse), 32'd0);
    chk("rst_is_note", 32'(is_note), 32'd0);
    chk("rst_ready", 32'(spawn_ready), 32'd1);
    Reset_n = 1'b1;

    // lanes 2,3 from tick 0; lanes 0,4 from tick 2; lane 1 from tick 85
    do_spawn(2);
    do_spawn(3);
    repeat (2) do_tick();
    do_spawn(0);
    do_spawn(4);
    repeat (83) do_tick();
    do_spawn(1);
    repeat (25) do_tick();

    // lane 1 note at y=100, lane 3 note at y=440
    pix_bit(200, 100, 1, 1'b1);
    pix_bit(247, 115, 1, 1'b1);
    pix_bit(200, 116, 1, 1'b0);
    pix_bit(248, 100, 1, 1'b0);
    pix_bit(360, 440, 3, 1'b1);
    check_pix(220, 440);

    // press lane 2 at y=440; a spawn into lane 2 lands on the pop cycle
    @(negedge Clk) lane_press = 5'b00100;
    @(negedge Clk) chk("hit_early1", 32'(hit_pulse), 32'd0);
    @(negedge Clk) chk("hit_early2", 32'(hit_pulse), 32'd0);
    spawn_valid = 1'b1;
    spawn_lane  = lane_idx_t'(2);
    #1 chk("ready_l2", 32'(spawn_ready), 32'd1);
    @(negedge Clk);
    chk("hit_l2", 32'(hit_pulse), 32'h04);
    chk("score_l2", 32'(score), 32'd10);
    chk("combo_l2", 32'(combo), 32'd1);
    spawn_valid = 1'b0;
    lane_press  = '0;
    @(negedge Clk) chk("hit_once", 32'(hit_pulse), 32'd0);
    model_judge(5'b00100);
    q[2].push_back(0);
    pix_bit(280, 440, 2, 1'b0);
    pix_bit(280, 0, 2, 1'b1);

    // ticks 111..114: lane 3 passes to y=456 and misses
    repeat (3) do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    chk("miss_early", 32'(miss_pulse), 32'd0);
    chk("combo_pre_miss", 32'(combo), 32'd1);
    @(negedge Clk);
    chk("miss_l3", 32'(miss_pulse), 32'h08);
    chk("combo_miss", 32'(combo), 32'd0);
    @(negedge Clk) chk("miss_once", 32'(miss_pulse), 32'd0);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    model_tick();
    pix_bit(360, 456, 3, 1'b0);
    check_totals();

    // lanes 0 and 4 (y=448) pressed together, combo 0
    @(negedge Clk) lane_press = 5'b10001;
    @(negedge Clk);
    @(negedge Clk) chk("dual_early", 32'(hit_pulse), 32'd0);
    @(negedge Clk);
    chk("dual_hit0", 32'(hit_pulse), 32'h01);
    chk("dual_score0", 32'(score), 32'd20);
    @(negedge Clk);
    chk("dual_hit4", 32'(hit_pulse), 32'h10);
    chk("dual_score4", 32'(score), 32'd31);
    chk("dual_combo", 32'(combo), 32'd2);
    @(negedge Clk) chk("dual_after", 32'(hit_pulse), 32'd0);
    repeat (4) @(negedge Clk);
    lane_press = '0;
    model_judge(5'b10001);
    check_totals();

    // ghost press on empty lane 3 clears combo
    do_press(5'b01000, 3);
    check_totals();

    // fill lane 0; spawn_ready follows the selected lane
    repeat (8) do_spawn(0);
    @(negedge Clk) spawn_lane = lane_idx_t'(0);
    #1 chk("full_l0", 32'(spawn_ready), 32'd0);
    spawn_lane = lane_idx_t'(1);
    #1 chk("ready_l1", 32'(spawn_ready), 32'd1);
    spawn_valid = 1'b1;
    spawn_lane  = lane_idx_t'(0);
    repeat (3) begin
      @(negedge Clk);
      #1 chk("held_spawn", 32'(spawn_ready), 32'd0);
    end
    spawn_valid = 1'b0;
    check_totals();

    // randomized spawns, ticks and presses against the model
    for (int it = 0; it < 450; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_spawn($urandom_range(0, NL-1));
      end else if (r < 8) begin
        do_tick();
      end else begin
        mask = '0;
        for (int k = 0; k < NL; k++)
          if (q[k].size() > 0 && q[k][0] >= 428 && q[k][0] <= 452) mask[k] = 1'b1;
        if (mask == '0 || $urandom_range(0, 2) == 0) mask = NL'($urandom_range(1, 31));
        do_press(mask, $urandom_range(1, 4));
      end
      l = $urandom_range(0, NL-1);
      if (q[l].size() > 0 && $urandom_range(0, 1) == 1) begin
        x = 120 + 80*l + $urandom_range(0, 49) - 1;
        y = q[l][$urandom_range(0, q[l].size()-1)] + $urandom_range(0, 17) - 1;
        if (y < 0) y = 0;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      check_pix(x, y);
      if (it % 10 == 0) check_totals();
    end
    check_totals();

    // async reset with live notes and a non-zero score
    do_spawn(1);
    do_spawn(2);
    do_spawn(3);
    @(negedge Clk);
    DrawX = 10'd200;
    DrawY = 10'd5;
    #3 Reset_n = 1'b0;
    #1;
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_combo", 32'(combo), 32'd0);
    chk("arst_hit", 32'(hit_pulse), 32'd0);
    chk("arst_miss", 32'(miss_pulse), 32'd0);
    chk("arst_is_note", 32'(is_note), 32'd0);
    chk("arst_ready", 32'(spawn_ready), 32'd1);
    for (int k = 0; k < NL; k++) q[k].delete();
    m_score = 0;
    m_combo = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check_totals();
    do_press(5'b11111, 2);
    check_totals();
    do_spawn(4);
    check_pix(440, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
